// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg
// Shared types and helpers for the round-robin Wishbone arbiter and for
// anything else that reuses its rotating-priority picker.
//   arb_state_e : arbiter state encoding (IDLE, OWN, ABORT)
//   idx_width() : width of a master index, never less than one bit
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    // A single master still needs a one-bit index so ports never collapse
    // to zero width.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick
// Combinational rotating-priority picker. The request vector is rotated so
// the master after last_idx sits at bit 0, priority encoded, and the winning
// offset is rotated back into a master index.
// Ports:
//   req      in  N   request bits, one per master
//   last_idx in  IW  index of the previous owner
//   vld      out 1   at least one request present
//   idx      out IW  winning master index (meaningful only when vld)
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_idx,
    output logic          vld,
    output logic [IW-1:0] idx
);

    logic [N-1:0] rot;
    int           start;
    int           off;

    // Rotate, find the lowest set bit, then undo the rotation.
    always_comb begin
        start = (int'(last_idx) + 1) % N;
        rot   = '0;
        for (int k = 0; k < N; k++) begin
            rot[k] = req[IW'((start + k) % N)];
        end
        off = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = k;
        end
        vld = |rot;
        idx = IW'((start + off) % N);
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr
// Round-robin Wishbone arbiter sharing one slave port among N_MASTERS
// masters. The grant is registered and held for the whole CYC of the owner,
// so bursts and read-modify-write sequences stay atomic; the datapath mux is
// combinational. Every change of owner passes through one IDLE cycle.
// Optional: define WB_ARB_TIMEOUT_EN to add a stall watchdog that aborts a
// hung transfer after TIMEOUT_CYCLES stalled cycles (ABORT state, one-cycle
// error to the owner).
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   m_adr/m_dat_w/m_sel/m_cti/m_bte packed master requests, master i at slice i
//   m_cyc/m_stb/m_we                per-master control
//   m_dat_r                         read data broadcast to all masters
//   m_ack/m_err                     per-master responses
//   s_*                             slave request/response
//   gnt                             one-hot current grant
module wb_arbiter_rr
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS      = 4,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]        m_adr,
    input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]        m_dat_w,
    input  logic [N_MASTERS*(WB_DATA_WIDTH/8)-1:0]    m_sel,
    input  logic [N_MASTERS*3-1:0]                    m_cti,
    input  logic [N_MASTERS*2-1:0]                    m_bte,
    input  logic [N_MASTERS-1:0]                      m_cyc,
    input  logic [N_MASTERS-1:0]                      m_stb,
    input  logic [N_MASTERS-1:0]                      m_we,
    output logic [WB_DATA_WIDTH-1:0]                  m_dat_r,
    output logic [N_MASTERS-1:0]                      m_ack,
    output logic [N_MASTERS-1:0]                      m_err,
    output logic [WB_ADDR_WIDTH-1:0]                  s_adr,
    output logic [WB_DATA_WIDTH-1:0]                  s_dat_w,
    output logic [WB_DATA_WIDTH/8-1:0]                s_sel,
    output logic [2:0]                                s_cti,
    output logic [1:0]                                s_bte,
    output logic                                      s_cyc,
    output logic                                      s_stb,
    output logic                                      s_we,
    input  logic [WB_DATA_WIDTH-1:0]                  s_dat_r,
    input  logic                                      s_ack,
    input  logic                                      s_err,
    output logic [N_MASTERS-1:0]                      gnt
);

    localparam int IW = idx_width(N_MASTERS);
    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;
    localparam int SW = WB_DATA_WIDTH / 8;

    arb_state_e    st_q;
    logic [IW-1:0] gnt_idx_q;
    logic [IW-1:0] last_idx_q;
    logic          pick_vld;
    logic [IW-1:0] pick_idx;
    logic          owner_cyc;
    logic          owner_stb;

    assign owner_cyc = m_cyc[gnt_idx_q];
    assign owner_stb = m_stb[gnt_idx_q];

    wb_rr_pick #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_pick (
        .req      (m_cyc),
        .last_idx (last_idx_q),
        .vld      (pick_vld),
        .idx      (pick_idx)
    );

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          abort_first_q;
    logic          stalled;

    // A strobe with no response this cycle is what the watchdog counts.
    assign stalled = owner_stb & ~s_ack & ~s_err;
`endif

    // Arbitration FSM. Ownership ends only when the owner drops CYC, and the
    // previous owner becomes the lowest priority for the next pick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= IDLE;
            gnt_idx_q  <= '0;
            last_idx_q <= IW'(N_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            abort_first_q <= 1'b0;
`endif
        end else begin
`ifdef WB_ARB_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            abort_first_q <= 1'b0;
`endif
            case (st_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_idx_q <= pick_idx;
                        st_q      <= OWN;
                    end
                end
                OWN: begin
                    if (!owner_cyc) begin
                        last_idx_q <= gnt_idx_q;
                        st_q       <= IDLE;
                    end
`ifdef WB_ARB_TIMEOUT_EN
                    else if (stalled && tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        st_q          <= ABORT;
                        abort_first_q <= 1'b1;
                    end else if (stalled) begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
`endif
                end
`ifdef WB_ARB_TIMEOUT_EN
                ABORT: begin
                    if (!owner_cyc) begin
                        last_idx_q <= gnt_idx_q;
                        st_q       <= IDLE;
                    end
                end
`endif
                default: st_q <= IDLE;
            endcase
        end
    end

    // Datapath mux: the owner drives the slave only while in OWN; responses
    // are steered back to the owner alone.
    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_cti   = '0;
        s_bte   = '0;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        m_ack   = '0;
        m_err   = '0;
        m_dat_r = '0;
        gnt     = '0;
        if (st_q == OWN) begin
            s_adr            = m_adr[gnt_idx_q*AW +: AW];
            s_dat_w          = m_dat_w[gnt_idx_q*DW +: DW];
            s_sel            = m_sel[gnt_idx_q*SW +: SW];
            s_cti            = m_cti[gnt_idx_q*3 +: 3];
            s_bte            = m_bte[gnt_idx_q*2 +: 2];
            s_cyc            = owner_cyc;
            s_stb            = owner_stb;
            s_we             = m_we[gnt_idx_q];
            m_ack[gnt_idx_q] = s_ack;
            m_err[gnt_idx_q] = s_err;
        end
`ifdef WB_ARB_TIMEOUT_EN
        if (st_q == ABORT) begin
            m_err[gnt_idx_q] = abort_first_q;
        end
`endif
        if (st_q != IDLE) begin
            m_dat_r        = s_dat_r;
            gnt[gnt_idx_q] = 1'b1;
        end
    end

endmodule
